// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Byte/halfword/word load-store engine between the RV32I
//               execute stage and a word-wide data memory. The memory is
//               word addressed, reads combinationally and writes one whole
//               word per enabled clock. Sub-word stores therefore run as
//               read-modify-write. Sub-word loads are sign- or zero-extended.
//               Misaligned accesses and illegal funct3 codes are reported.
//               Only one transaction is in flight at a time.
// Ports       : i_lsu_clk / i_lsu_rst_n   clock, async active-low reset
//               i_lsu_valid / o_lsu_ready valid/ready request handshake
//               i_lsu_we, i_lsu_funct3    store/load select, access size
//               i_lsu_addr, i_lsu_wdata   byte address, store data
//               o_lsu_done, o_lsu_err     one-cycle completion pulse + error
//               o_lsu_rdata               extended load data (held)
//               o_lsu_mem_A/WD/WE         word-aligned memory address,
//                                         write data, write enable
//               i_lsu_mem_RD              combinational memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic        i_lsu_clk,
  input  logic        i_lsu_rst_n,
  input  logic        i_lsu_valid,
  output logic        o_lsu_ready,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_done,
  output logic        o_lsu_err,
  output logic [31:0] o_lsu_rdata,
  output logic [31:0] o_lsu_mem_A,
  output logic [31:0] o_lsu_mem_WD,
  output logic        o_lsu_mem_WE,
  input  logic [31:0] i_lsu_mem_RD
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_q,  state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q,   addr_d;
  // Holds raw store data after accept; replaced by the merged word in RMW_RD.
  logic [31:0] wd_q,     wd_d;
  logic [31:0] rdata_q,  rdata_d;
  logic        done_q,   done_d;
  logic        err_q,    err_d;

  // Request decode
  logic        f3_legal;
  logic        misaligned;
  logic        req_bad;
  logic [31:0] req_addr;

  always_comb begin
    f3_legal = 1'b0;
    case (i_lsu_funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~i_lsu_we;   // no unsigned stores
      default:          f3_legal = 1'b0;
    endcase

    misaligned = 1'b0;
    req_addr   = i_lsu_addr;
    if (i_lsu_funct3[1:0] == 2'b01) begin
      misaligned = i_lsu_addr[0];
      if (!MISALIGN_TRAP) req_addr[0] = 1'b0;
    end else if (i_lsu_funct3[1:0] == 2'b10) begin
      misaligned = |i_lsu_addr[1:0];
      if (!MISALIGN_TRAP) req_addr[1:0] = 2'b00;
    end

    // Illegal funct3 always errors; misalignment only errors when trapping.
    req_bad = ~f3_legal | (MISALIGN_TRAP & misaligned);
  end

  // Load lane selection and extension
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  always_comb begin
    lane_byte = 8'h00;
    case (addr_q[1:0])
      2'd0:    lane_byte = i_lsu_mem_RD[7:0];
      2'd1:    lane_byte = i_lsu_mem_RD[15:8];
      2'd2:    lane_byte = i_lsu_mem_RD[23:16];
      default: lane_byte = i_lsu_mem_RD[31:24];
    endcase
    lane_half = addr_q[1] ? i_lsu_mem_RD[31:16] : i_lsu_mem_RD[15:0];

    load_ext = i_lsu_mem_RD;
    case (funct3_q)
      F3_B:    load_ext = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_ext = {{16{lane_half[15]}}, lane_half};
      F3_BU:   load_ext = {24'h000000, lane_byte};
      F3_HU:   load_ext = {16'h0000, lane_half};
      default: load_ext = i_lsu_mem_RD;
    endcase
  end

  // Sub-word store merge into the word just read back
  logic [31:0] merged;

  always_comb begin
    merged = i_lsu_mem_RD;
    if (funct3_q == F3_H) begin
      if (addr_q[1]) merged[31:16] = wd_q[15:0];
      else           merged[15:0]  = wd_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wd_q[7:0];
        2'd1:    merged[15:8]  = wd_q[7:0];
        2'd2:    merged[23:16] = wd_q[7:0];
        default: merged[31:24] = wd_q[7:0];
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_lsu_valid) begin
          funct3_d = i_lsu_funct3;
          addr_d   = req_addr;
          wd_d     = i_lsu_wdata;
          if (req_bad)                  state_d = S_ERR;
          else if (!i_lsu_we)           state_d = S_LOAD;
          else if (i_lsu_funct3 == F3_W) state_d = S_WRITE;
          else                          state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rdata_d = load_ext;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_RMW_RD: begin
        wd_d    = merged;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_lsu_clk or negedge i_lsu_rst_n) begin
    if (!i_lsu_rst_n) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wd_q     <= 32'h0;
      rdata_q  <= 32'h0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // WE decodes straight from state so reset removes it without waiting a clock.
  assign o_lsu_ready  = (state_q == S_IDLE);
  assign o_lsu_done   = done_q;
  assign o_lsu_err    = err_q;
  assign o_lsu_rdata  = rdata_q;
  assign o_lsu_mem_A  = {addr_q[31:2], 2'b00};
  assign o_lsu_mem_WD = wd_q;
  assign o_lsu_mem_WE = (state_q == S_WRITE);

endmodule
`default_nettype wire
